// File: rtl/irq_priority_ctrl.sv
// Three-line nested interrupt controller with EPC/level stack.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module irq_priority_ctrl #(
  parameter int WIDTH = 32,
  parameter int NUM_IRQ = 3,
  parameter int NEST_DEPTH = 3,
  parameter logic [WIDTH-1:0] VEC_BASE = 32'h0000_0100,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0040
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               int_en,
  input  logic               int_ack,
  input  logic [WIDTH-1:0]   epc_in,
  input  logic               eret,
  output logic               int_req,
  output logic [1:0]         int_id,
  output logic [WIDTH-1:0]   int_vec,
  output logic [WIDTH-1:0]   epc_out,
  output logic [NUM_IRQ-1:0] IRW,
  output logic [1:0]         cur_level,
  output logic [1:0]         depth
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [1:0] DMAX = 2'(NEST_DEPTH);

  state_t             state;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [WIDTH-1:0]   stk_pc [NEST_DEPTH];
  logic [1:0]         stk_lv [NEST_DEPTH];
  logic [1:0]         cand;
  logic [1:0]         top;
  logic               elig;
  logic               push;
  logic               pop;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= IRQ;
      sync2 <= sync1;
    end
  end

  assign irq_d = sync2;
`else
  assign irq_d = IRQ;
`endif

  assign rise = irq_d & ~irq_prev;

  always_comb begin
    cand = 2'd0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (pend[i]) cand = 2'(i);
  end

  // Only a line strictly above the level in service may preempt it.
  assign elig = (|pend) && int_en
             && ({1'b0, cand} + 3'd1 > {1'b0, cur_level})
             && (depth < DMAX);

  assign push = (state == REQ) && int_ack;
  assign pop  = eret && (depth != 2'd0);
  assign top  = depth - 2'd1;
  assign clr  = push ? (NUM_IRQ'(1) << int_id) : '0;

  assign IRW     = pend;
  assign epc_out = (depth == 2'd0) ? '0 : stk_pc[top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= '0;
      pend     <= '0;
    end else begin
      irq_prev <= irq_d;
      pend     <= (pend & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      int_req <= 1'b0;
      int_id  <= 2'd0;
      int_vec <= VEC_BASE;
    end else begin
      unique case (state)
        IDLE: if (elig) begin
          int_req <= 1'b1;
          int_id  <= cand;
          int_vec <= VEC_BASE + WIDTH'(cand) * VEC_STRIDE;
          state   <= REQ;
        end
        REQ: if (int_ack) begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ack with eret: the popped slot is reused, keeping its saved level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth     <= 2'd0;
      cur_level <= 2'd0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_pc[i] <= '0;
        stk_lv[i] <= 2'd0;
      end
    end else if (push && pop) begin
      stk_pc[top] <= epc_in;
      cur_level   <= int_id + 2'd1;
    end else if (push && depth < DMAX) begin
      stk_pc[depth] <= epc_in;
      stk_lv[depth] <= cur_level;
      depth         <= depth + 2'd1;
      cur_level     <= int_id + 2'd1;
    end else if (pop) begin
      cur_level <= stk_lv[top];
      depth     <= top;
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed steps plus random traffic,
// all checked against a queue-based reference model.
module tb_irq_priority_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  IRQ = '0;
  logic        int_en = 1'b1;
  logic        int_ack = 1'b0;
  logic [31:0] epc_in = '0;
  logic        eret = 1'b0;
  logic        int_req;
  logic [1:0]  int_id;
  logic [31:0] int_vec;
  logic [31:0] epc_out;
  logic [2:0]  IRW;
  logic [1:0]  cur_level;
  logic [1:0]  depth;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] pc;
    int          lv;
  } ent_t;

  logic [2:0] m_pend;
  logic [2:0] m_prev;
  logic       m_req;
  int         m_id;
  int         m_lvl;
  ent_t       m_stk[$];

  irq_priority_ctrl dut (
    .clk(clk), .rst(rst), .IRQ(IRQ), .int_en(int_en),
    .int_ack(int_ack), .epc_in(epc_in), .eret(eret),
    .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
    .epc_out(epc_out), .IRW(IRW), .cur_level(cur_level),
    .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pend = '0;
    m_prev = '0;
    m_req  = 1'b0;
    m_id   = 0;
    m_lvl  = 0;
    m_stk.delete();
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge();
    logic [2:0] rise;
    int   cand;
    bit   elig, push, pop;
    ent_t e;
    rise = IRQ & ~m_prev;
    m_prev = IRQ;
    cand = 0;
    for (int i = 0; i < 3; i++) if (m_pend[i]) cand = i;
    elig = (m_pend != 0) && int_en && (cand + 1 > m_lvl)
        && (m_stk.size() < 3);
    pop  = eret && (m_stk.size() > 0);
    push = m_req && int_ack;
    if (pop) begin
      e = m_stk.pop_back();
      m_lvl = e.lv;
    end
    if (push) begin
      m_stk.push_back('{epc_in, m_lvl});
      m_lvl = m_id + 1;
      m_pend[m_id] = 1'b0;
    end
    m_pend |= rise;
    if (push) m_req = 1'b0;
    else if (!m_req && elig) begin
      m_req = 1'b1;
      m_id  = cand;
    end
  endtask

  task automatic cmp_all(input string tag);
    logic [31:0] ep;
    ep = (m_stk.size() > 0) ? m_stk[$].pc : 32'h0;
    chk({tag, ".req"}, 32'(int_req), 32'(m_req));
    chk({tag, ".id"}, 32'(int_id), 32'(m_id));
    chk({tag, ".vec"}, int_vec, 32'h100 + 32'(m_id) * 32'h40);
    chk({tag, ".epc"}, epc_out, ep);
    chk({tag, ".irw"}, 32'(IRW), 32'(m_pend));
    chk({tag, ".lvl"}, 32'(cur_level), 32'(m_lvl));
    chk({tag, ".dep"}, 32'(depth), 32'(m_stk.size()));
  endtask

  // Called at posedge+1; leaves time at the next posedge+1.
  task automatic step(input logic [2:0] irq_v, input logic ack_v,
                      input logic [31:0] epc_v, input logic eret_v);
    IRQ = irq_v;
    int_ack = ack_v;
    epc_in = epc_v;
    eret = eret_v;
    @(posedge clk);
    model_edge();
    #1;
    cmp_all("cyc");
  endtask

  // One-nanosecond reset pulse, checked with no clock edge in between.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    IRQ = '0;
    int_ack = 1'b0;
    eret = 1'b0;
    int_en = 1'b1;
    #1;
    chk({tag, ".req"}, 32'(int_req), 32'h0);
    chk({tag, ".id"}, 32'(int_id), 32'h0);
    chk({tag, ".vec"}, int_vec, 32'h100);
    chk({tag, ".epc"}, epc_out, 32'h0);
    chk({tag, ".irw"}, 32'(IRW), 32'h0);
    chk({tag, ".lvl"}, 32'(cur_level), 32'h0);
    chk({tag, ".dep"}, 32'(depth), 32'h0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int rises, sets;
    logic prev_req, prev_irw;
    logic [2:0] r;
    model_clear();
    @(posedge clk);
    #1;
    do_reset("rst0");

    // 1: single line, ack two cycles after request
    step(3'b001, 0, 0, 0);
    chk("t1.pend", 32'(IRW), 32'h1);
    chk("t1.noreq", 32'(int_req), 32'h0);
    step(3'b001, 0, 0, 0);
    chk("t1.req", 32'(int_req), 32'h1);
    chk("t1.vec", int_vec, 32'h100);
    step(3'b001, 0, 0, 0);
    step(3'b000, 1, 32'h40, 0);
    chk("t1.irw", 32'(IRW), 32'h0);
    chk("t1.lvl", 32'(cur_level), 32'h1);
    chk("t1.dep", 32'(depth), 32'h1);
    chk("t1.epc", epc_out, 32'h40);
    step(3'b000, 0, 0, 1);

    // 2: simultaneous edges, highest first, low one waits for eret
    step(3'b101, 0, 0, 0);
    step(3'b101, 0, 0, 0);
    chk("t2.id", 32'(int_id), 32'h2);
    chk("t2.vec", int_vec, 32'h180);
    step(3'b000, 1, 32'h200, 0);
    chk("t2.irw", 32'(IRW), 32'h1);
    step(3'b000, 0, 0, 0);
    chk("t2.blocked", 32'(int_req), 32'h0);
    step(3'b000, 0, 0, 1);
    chk("t2.lvl0", 32'(cur_level), 32'h0);
    step(3'b000, 0, 0, 0);
    chk("t2.req0", 32'(int_req), 32'h1);
    chk("t2.id0", 32'(int_id), 32'h0);
    step(3'b000, 1, 32'h44, 0);
    step(3'b000, 0, 0, 1);

    // 3: nesting and unwinding
    step(3'b001, 0, 0, 0);
    step(3'b001, 0, 0, 0);
    step(3'b000, 1, 32'h40, 0);
    step(3'b010, 0, 0, 0);
    step(3'b010, 0, 0, 0);
    chk("t3.id1", 32'(int_id), 32'h1);
    step(3'b000, 1, 32'h108, 0);
    chk("t3.dep2", 32'(depth), 32'h2);
    chk("t3.epc2", epc_out, 32'h108);
    step(3'b000, 0, 0, 1);
    chk("t3.epc1", epc_out, 32'h40);
    chk("t3.lvl1", 32'(cur_level), 32'h1);
    step(3'b000, 0, 0, 1);
    chk("t3.dep0", 32'(depth), 32'h0);
    chk("t3.epc0", epc_out, 32'h0);

    // 4: masked by int_en
    int_en = 1'b0;
    step(3'b010, 0, 0, 0);
    step(3'b010, 0, 0, 0);
    step(3'b010, 0, 0, 0);
    chk("t4.irw", 32'(IRW), 32'h2);
    chk("t4.noreq", 32'(int_req), 32'h0);
    int_en = 1'b1;
    step(3'b010, 0, 0, 0);
    chk("t4.req", 32'(int_req), 32'h1);
    step(3'b000, 1, 32'h80, 0);
    step(3'b000, 0, 0, 1);

    // 5: held level gives one request; edge coinciding with ack keeps pend
    rises = 0;
    sets = 0;
    prev_req = int_req;
    prev_irw = IRW[0];
    for (int i = 0; i < 20; i++) begin
      step(3'b001, m_req, 32'h300, 0);
      if (int_req && !prev_req) rises++;
      if (IRW[0] && !prev_irw) sets++;
      prev_req = int_req;
      prev_irw = IRW[0];
    end
    chk("t5.rises", 32'(rises), 32'h1);
    chk("t5.sets", 32'(sets), 32'h1);
    step(3'b000, 0, 0, 1);
    step(3'b001, 0, 0, 0);
    step(3'b001, 0, 0, 0);
    step(3'b000, 0, 0, 0);
    step(3'b001, 1, 32'h400, 0);
    chk("t5.keep", 32'(IRW[0]), 32'h1);
    chk("t5.dep", 32'(depth), 32'h1);

    // 6: asynchronous reset mid-request with two nested handlers
    do_reset("rst1");
    step(3'b001, 0, 0, 0);
    step(3'b001, 0, 0, 0);
    step(3'b000, 1, 32'h40, 0);
    step(3'b010, 0, 0, 0);
    step(3'b010, 0, 0, 0);
    step(3'b000, 1, 32'h108, 0);
    step(3'b100, 0, 0, 0);
    step(3'b100, 0, 0, 0);
    chk("t6.req", 32'(int_req), 32'h1);
    chk("t6.dep", 32'(depth), 32'h2);
    do_reset("t6");

    // Random traffic against the model
    r = '0;
    for (int i = 0; i < 600; i++) begin
      r ^= 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7))
         & 3'($urandom_range(0, 7));
      int_en = ($urandom_range(0, 7) != 0);
      step(r, m_req && ($urandom_range(0, 2) == 0),
           $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
Three-line nested interrupt controller for the pipelined RISC-V CPU.
- Edge-detects and latches IRQ lines, then selects the highest-priority pending line above the current service level.
- Runs a req/ack handshake with the pipeline's flush/redirect logic.
- Keeps a return-address/level stack so that nested handlers unwind correctly on eret.

Parameters:
WIDTH, 32, address/data width of PCs and vectors
NUM_IRQ, 3, number of interrupt lines (line NUM_IRQ-1 is highest priority)
NEST_DEPTH, 3, depth of the EPC/level stack
VEC_BASE, 32'h0000_0100, handler vector for line 0
VEC_STRIDE, 32'h0000_0040, address spacing between handler vectors

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
IRQ  in  NUM_IRQ  raw level interrupt requests (buttons/timer)
int_en  in  1  global interrupt enable from CSR logic
int_ack  in  1  pipeline has flushed and redirected to int_vec; one-cycle pulse
epc_in  in  WIDTH  return PC supplied by the pipeline, valid with int_ack
eret  in  1  handler return (uret/mret) retiring; one-cycle pulse
int_req  out  1  interrupt request to the pipeline
int_id  out  2  index of the requested line
int_vec  out  WIDTH  handler address, VEC_BASE + int_id*VEC_STRIDE
epc_out  out  WIDTH  top-of-stack return PC; 0 when the stack is empty
IRW  out  NUM_IRQ  pending (waiting) bits, one per line
cur_level  out  2  0 = no handler running, k = line k-1 in service
depth  out  2  current stack occupancy

Behaviour:
Reset (asynchronous, rst=1), all cleared:
- IRW=0, int_req=0, int_id=0, int_vec=VEC_BASE
- cur_level=0, depth=0, epc_out=0
- Edge-detect history cleared, FSM to IDLE.

Edge capture:
- pend[i] is set at the first rising clk where IRQ[i] is sampled 1 and the previous sample was 0. Holding a level high produces no further sets.
- pend[i] clears only when int_ack is received for line i.
- If the ack and a new edge on the same line occur in the same cycle, the set wins and pend stays 1.
- IRW = pend.

Selection (combinational):
- cand = highest i with pend[i]=1.
- eligible = pend nonzero, int_en=1, cand+1 > cur_level, and depth < NEST_DEPTH.

FSM:
- IDLE: when eligible, register int_id=cand and int_vec, set int_req=1, go to REQ. int_req therefore rises 1 cycle after the pend bit sets.
- REQ: int_id/int_vec are held stable, even if a higher line becomes pending or int_en drops. On int_ack:
  - push {epc_in, cur_level} onto the stack, depth++
  - cur_level = int_id+1
  - clear pend[int_id]
  - int_req=0, go to IDLE.
- A re-request cannot issue in the cycle after ack, because int_req is registered. The earliest next int_req is 1 cycle after returning to IDLE.

eret:
- When depth>0: pop, cur_level = saved level, depth--. epc_out shows the new top, or 0 if empty.
- When depth=0: ignored (no underflow).
- eret together with int_ack in the same cycle: pop first, then push; depth is unchanged. cur_level takes the new line and the pushed level is the popped level.
- eret while in REQ without ack: pop is applied and the request stays unchanged.

Stack:
- Registers are NEST_DEPTH x (WIDTH+2).
- No push occurs when full, because eligible already blocks the request.

Reset mid-operation: all state, including the stack and pending bits, clears immediately. Outstanding requests are lost.

Optional Feature:
IRQ_SYNC_EN
- Defined: a 2-flop synchronizer sits in front of the edge detector. Pend sets 2 cycles later than without it, so int_req rises 3 cycles after the first rising edge where IRQ is high.
- Undefined: IRQ feeds the edge detector directly, and int_req rises 1 cycle after pend sets.

Test Plan:
1. Reset, then pulse IRQ=3'b001 high for 3 cycles, ack 2 cycles after int_req with epc_in=32'h0000_0040 -> pend bit set on the first sampled edge; int_req rises 1 cycle later (without IRQ_SYNC_EN); int_id=0, int_vec=32'h100; on ack IRW=0, cur_level=1, depth=1, epc_out=32'h40.
2. IRQ[0] and IRQ[2] rise in the same cycle -> int_id=2, int_vec=32'h180 first. After its ack IRW=3'b001 with no request (level 3 > 1). After eret, cur_level=0 and a request follows with int_id=0.
3. Nesting: serve line 0 (epc 32'h40), then IRQ[1] edge -> request id=1, ack with epc 32'h108; depth=2, epc_out=32'h108. eret -> epc_out=32'h40, cur_level=1. Second eret -> depth=0, epc_out=0.
4. int_en=0 while IRQ[1] edge arrives -> IRW=3'b010, int_req stays 0. int_en=1 -> int_req asserts next cycle.
5. Hold IRQ[0] high for 20 cycles -> exactly one pend set and one request. A second edge arriving in the same cycle as its ack -> IRW[0] remains 1.
6. Assert rst for 1 ns while int_req=1 and depth=2 -> all outputs zero and int_vec=VEC_BASE immediately, with no clk edge required.
